// File: rtl/conv_pkg.sv
// Shared types and constants for the 2D convolution datapath.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CONVOLVE = 3'd3,
    ST_DONE     = 3'd4
  } conv_state_e;

  localparam int PIX_W  = 8;
  localparam int RES_W  = 16;
  localparam int PROD_W = 16;

  function automatic int conv_out_dim(input int img_dim, input int flt_dim);
    return img_dim - flt_dim + 1;
  endfunction

  // Accumulator must hold the sum of all taps without overflow, and never narrower than 20 bits.
  function automatic int conv_acc_width(input int taps);
    int w;
    w = PROD_W + $clog2(taps);
    if (w < 20) begin
      w = 20;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Combinational FILTER_SIZE x FILTER_SIZE unsigned multiply-accumulate with 16-bit reduction.
// Build option: CONV_SATURATE_EN clamps sums above 65535; otherwise the sum wraps modulo 2^16.
module conv_mac
  import conv_pkg::*;
#(
  parameter int FILTER_SIZE = 3
) (
  input  logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0] i_window,
  input  logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0] i_filter,
  output logic [RES_W-1:0]                         o_result
);

  localparam int TAPS  = FILTER_SIZE * FILTER_SIZE;
  localparam int ACC_W = conv_acc_width(TAPS);

  logic [ACC_W-1:0] w_acc;

  // Sum of all tap products at full precision
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'({8'd0, i_window[k*PIX_W +: PIX_W]} * {8'd0, i_filter[k*PIX_W +: PIX_W]});
    end
  end

  // Reduce the accumulator to the result width
  always_comb begin
`ifdef CONV_SATURATE_EN
    if (w_acc > ACC_W'(17'h0FFFF)) begin
      o_result = 16'hFFFF;
    end else begin
      o_result = RES_W'(w_acc);
    end
`else
    o_result = RES_W'(w_acc);
`endif
  end

endmodule

// File: rtl/conv2d_top.sv
// Sequential 2D convolution engine: FSM walks row bands, extracts windows and writes one result per CONVOLVE.
// Build option: CONV_SATURATE_EN (passed through to conv_mac) selects saturating instead of wrapping results.
module conv2d_top
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int FILTER_SIZE  = 3,
  parameter int OUT          = conv_out_dim(IMAGE_HEIGHT, FILTER_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [IMAGE_HEIGHT*IMAGE_WIDTH*PIX_W-1:0] image,
  input  logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0]  filter,
  output logic [OUT*OUT*RES_W-1:0]                  result,
  output logic                                      load_done,
  output logic                                      shift_done,
  output logic                                      convolve_done,
  output logic                                      done
);

  localparam int IMG_BITS = IMAGE_HEIGHT * IMAGE_WIDTH * PIX_W;
  localparam int FLT_BITS = FILTER_SIZE * FILTER_SIZE * PIX_W;
  localparam int ROW_BITS = FILTER_SIZE * IMAGE_WIDTH * PIX_W;
  localparam int RES_BITS = OUT * OUT * RES_W;
  localparam int CNT_W    = (OUT > 1) ? $clog2(OUT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT - 1);

  conv_state_e      r_state;
  conv_state_e      w_next_state;
  logic [CNT_W-1:0] r_row_count;
  logic [CNT_W-1:0] r_col_count;
  logic [IMG_BITS-1:0] r_image;
  logic [FLT_BITS-1:0] r_filter;
  logic [ROW_BITS-1:0] r_rows;
  logic [FLT_BITS-1:0] r_window;
  logic                r_window_valid;
  logic [RES_BITS-1:0] r_result;
  logic                r_load_done;
  logic                r_shift_done;
  logic                r_convolve_done;
  logic                r_done;
  logic                w_load_pulse;
  logic                w_shift_pulse;
  logic                w_conv_pulse;
  logic [RES_W-1:0]    w_mac_result;

  conv_mac #(
    .FILTER_SIZE(FILTER_SIZE)
  ) u_mac (
    .i_window(r_window),
    .i_filter(r_filter),
    .o_result(w_mac_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and phase strobe decode
  always_comb begin
    w_next_state  = r_state;
    w_load_pulse  = 1'b0;
    w_shift_pulse = 1'b0;
    w_conv_pulse  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_load_pulse = 1'b1;
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift_pulse = 1'b1;
        w_next_state  = ST_CONVOLVE;
      end
      ST_CONVOLVE: begin
        w_conv_pulse = 1'b1;
        if (r_col_count < LAST_IDX) begin
          w_next_state = ST_SHIFT;
        end else if (r_row_count < LAST_IDX) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: input latch, row buffer, window, results, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_count     <= '0;
      r_col_count     <= '0;
      r_image         <= '0;
      r_filter        <= '0;
      r_rows          <= '0;
      r_window        <= '0;
      r_window_valid  <= 1'b0;
      r_result        <= '0;
      r_load_done     <= 1'b0;
      r_shift_done    <= 1'b0;
      r_convolve_done <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_load_done     <= w_load_pulse;
      r_shift_done    <= w_shift_pulse;
      r_convolve_done <= w_conv_pulse;
      r_done          <= (w_next_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          r_image  <= image;
          r_filter <= filter;
        end
        ST_LOAD: begin
          for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int c = 0; c < IMAGE_WIDTH; c++) begin
              r_rows[(i*IMAGE_WIDTH+c)*PIX_W +: PIX_W] <=
                r_image[((int'(r_row_count)+i)*IMAGE_WIDTH+c)*PIX_W +: PIX_W];
            end
          end
        end
        ST_SHIFT: begin
          for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < FILTER_SIZE; j++) begin
              r_window[(i*FILTER_SIZE+j)*PIX_W +: PIX_W] <=
                r_rows[(i*IMAGE_WIDTH+int'(r_col_count)+j)*PIX_W +: PIX_W];
            end
          end
          r_window_valid <= 1'b1;
        end
        ST_CONVOLVE: begin
          if (r_window_valid) begin
            r_result[(int'(r_row_count)*OUT+int'(r_col_count))*RES_W +: RES_W] <= w_mac_result;
          end else begin
            r_result <= r_result;
          end
          r_window_valid <= 1'b0;
          if (r_col_count < LAST_IDX) begin
            r_col_count <= r_col_count + CNT_W'(1);
          end else begin
            r_col_count <= '0;
            if (r_row_count < LAST_IDX) begin
              r_row_count <= r_row_count + CNT_W'(1);
            end else begin
              r_row_count <= r_row_count;
            end
          end
        end
        default: begin
          r_row_count <= r_row_count;
        end
      endcase
    end
  end

  assign result        = r_result;
  assign load_done     = r_load_done;
  assign shift_done    = r_shift_done;
  assign convolve_done = r_convolve_done;
  assign done          = r_done;

endmodule

// File: tb/tb_conv2d_top.sv
// Scoreboard bench for conv2d_top: reference convolution pushes expected result-bus snapshots, a monitor pops on convolve_done.
module tb_conv2d_top;

  localparam int W  = 5;
  localparam int FS = 3;
  localparam int O  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [199:0] image = '0;
  logic [71:0]  filter = '0;
  logic [143:0] result;
  logic         load_done, shift_done, convolve_done, done;

  int checks = 0;
  int errors = 0;
  int n_load = 0;
  int n_shift = 0;
  int n_conv = 0;
  logic [143:0] sb_q[$];
  logic [143:0] final_exp;
  int img_m[W*W];
  int flt_m[FS*FS];

  always #5 clk = ~clk;

  conv2d_top dut (
    .clk(clk), .rst(rst), .image(image), .filter(filter), .result(result),
    .load_done(load_done), .shift_done(shift_done), .convolve_done(convolve_done), .done(done)
  );

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_out(input int r, input int c);
    int sum = 0;
    for (int i = 0; i < FS; i++)
      for (int j = 0; j < FS; j++)
        sum += img_m[(r+i)*W + c + j] * flt_m[i*FS + j];
`ifdef CONV_SATURATE_EN
    return (sum > 65535) ? 65535 : sum;
`else
    return sum % 65536;
`endif
  endfunction

  // Monitor: strobe exclusivity, strobe counts, and scoreboard pops on each written output
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      n_load = 0; n_shift = 0; n_conv = 0;
    end else begin
      check("strobe_onehot0", 144'($onehot0({load_done, shift_done, convolve_done})), 144'd1);
      n_load  += int'(load_done);
      n_shift += int'(shift_done);
      n_conv  += int'(convolve_done);
      if (convolve_done) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got convolve_done with result %0h, expected no output", result);
        end else begin
          check("result_bus", result, sb_q.pop_front());
        end
      end
    end
  end

  task automatic apply_reset_and_start();
    logic [143:0] exp;
    for (int k = 0; k < W*W; k++) image[k*8 +: 8] = 8'(img_m[k]);
    for (int k = 0; k < FS*FS; k++) filter[k*8 +: 8] = 8'(flt_m[k]);
    rst = 1'b1;
    #1;
    check("rst_async_result", result, 144'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_result", result, 144'd0);
    check("rst_held_flags", 144'({done, load_done, shift_done, convolve_done}), 144'd0);
    #2;
    exp = '0;
    for (int k = 0; k < O*O; k++) begin
      exp[k*16 +: 16] = 16'(ref_out(k / O, k % O));
      sb_q.push_back(exp);
    end
    final_exp = exp;
    rst = 1'b0;
  endtask

  task automatic run_case(input bit perturb);
    apply_reset_and_start();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 21) check("done_not_early", 144'(done), 144'd0);
      if (cyc == 22) check("done_at_22", 144'(done), 144'd1);
      if (perturb) for (int k = 0; k < W*W; k++) image[k*8 +: 8] = 8'($urandom_range(0, 255));
    end
    check("final_result", result, final_exp);
    check("load_count", 144'(n_load), 144'd3);
    check("shift_count", 144'(n_shift), 144'd9);
    check("conv_count", 144'(n_conv), 144'd9);
    check("sb_drained", 144'(sb_q.size()), 144'd0);
  endtask

  task automatic set_seq_image();
    for (int k = 0; k < W*W; k++) img_m[k] = k + 1;
  endtask

  initial begin
    // Sequential image, all-ones filter
    set_seq_image();
    for (int k = 0; k < FS*FS; k++) flt_m[k] = 1;
    run_case(1'b0);
    check("tp1_r00", 144'(result[15:0]), 144'd63);
    check("tp1_r11", 144'(result[4*16 +: 16]), 144'd117);
    check("tp1_r22", 144'(result[8*16 +: 16]), 144'd171);
    repeat (5) @(posedge clk);
    #1;
    check("done_sticky", 144'(done), 144'd1);
    check("hold_result", result, final_exp);
    check("hold_no_strobes", 144'(n_conv + n_load + n_shift), 144'd21);

    // Centre-tap filter
    for (int k = 0; k < FS*FS; k++) flt_m[k] = (k == 4) ? 1 : 0;
    run_case(1'b0);
    check("tp2_r00", 144'(result[15:0]), 144'd7);
    check("tp2_r11", 144'(result[4*16 +: 16]), 144'd13);
    check("tp2_r22", 144'(result[8*16 +: 16]), 144'd19);

    // All 255: overflow of the 16-bit result
    for (int k = 0; k < W*W; k++) img_m[k] = 255;
    for (int k = 0; k < FS*FS; k++) flt_m[k] = 255;
    run_case(1'b0);
`ifdef CONV_SATURATE_EN
    check("tp3_r00", 144'(result[15:0]), 144'd65535);
`else
    check("tp3_r00", 144'(result[15:0]), 144'd60937);
`endif

    // Reset during the 5th CONVOLVE, then a full run
    set_seq_image();
    for (int k = 0; k < FS*FS; k++) flt_m[k] = 1;
    apply_reset_and_start();
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 144'd0);
    check("midrst_flags", 144'({done, load_done, shift_done, convolve_done}), 144'd0);
    check("midrst_conv_seen", 144'(n_conv), 144'd4);
    run_case(1'b0);

    // Random images and filters; one run perturbs the image after it is latched
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < W*W; k++) img_m[k] = int'($urandom_range(0, 255));
      for (int k = 0; k < FS*FS; k++) flt_m[k] = int'($urandom_range(0, 255));
      run_case(t == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
